vga_timing_gen: RTL and testbench

Parametrised, runtime-programmable VGA timing generator: the next generation of the fixed 1024x768 timing block. It produces pixel coordinates, sync, blank, frame/line strobes, a frame counter and a three-source maskable interrupt for the display pipeline and the TinyQV peripheral interrupt line. Mode timings live in shadow registers. Writes are buffered and applied atomically at the frame boundary, so a mode change never produces a torn frame.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 76 +++++++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: register map,
// interrupt bit positions and the 1024x768 reset mode.
package vga_timing_pkg;

    localparam logic [3:0] ADDR_H_ACTIVE     = 4'd0;
    localparam logic [3:0] ADDR_H_SYNC_START = 4'd1;
    localparam logic [3:0] ADDR_H_SYNC_END   = 4'd2;
    localparam logic [3:0] ADDR_H_TOTAL      = 4'd3;
    localparam logic [3:0] ADDR_V_ACTIVE     = 4'd4;
    localparam logic [3:0] ADDR_V_SYNC_START = 4'd5;
    localparam logic [3:0] ADDR_V_SYNC_END   = 4'd6;
    localparam logic [3:0] ADDR_V_TOTAL      = 4'd7;
    localparam logic [3:0] ADDR_IRQ_LINE     = 4'd8;

    localparam int IRQ_HBLANK = 0;
    localparam int IRQ_VBLANK = 1;
    localparam int IRQ_LINE   = 2;

    localparam int MODE_H_ACTIVE     = 1024;
    localparam int MODE_H_SYNC_START = 1072;
    localparam int MODE_H_SYNC_END   = 1176;
    localparam int MODE_H_TOTAL      = 1327;
    localparam int MODE_V_ACTIVE     = 768;
    localparam int MODE_V_SYNC_START = 771;
    localparam int MODE_V_SYNC_END   = 775;
    localparam int MODE_V_TOTAL      = 797;

    // Low two address bits select the register within one axis.
    typedef enum logic [1:0] {
        REG_ACTIVE     = 2'd0,
        REG_SYNC_START = 2'd1,
        REG_SYNC_END   = 2'd2,
        REG_TOTAL      = 2'd3
    } axis_reg_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter, shadow/active timing registers
// and the active-region and sync decodes of the current position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W              = 11,
    parameter int DEF_ACTIVE     = MODE_H_ACTIVE,
    parameter int DEF_SYNC_START = MODE_H_SYNC_START,
    parameter int DEF_SYNC_END   = MODE_H_SYNC_END,
    parameter int DEF_TOTAL      = MODE_H_TOTAL,
    parameter bit POL            = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          load,
    input  logic          wr,
    input  axis_reg_e     sel,
    input  logic [W-1:0]  data,
    output logic [W-1:0]  pos,
    output logic          at_total,
    output logic          at_active,
    output logic          in_active,
    output logic          sync
);

    logic [W-1:0] sh_active, sh_sync_start, sh_sync_end, sh_total;
    logic [W-1:0] act_active, act_sync_start, act_sync_end, act_total;
    logic         sync_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_active     <= W'(DEF_ACTIVE);
            sh_sync_start <= W'(DEF_SYNC_START);
            sh_sync_end   <= W'(DEF_SYNC_END);
            sh_total      <= W'(DEF_TOTAL);
        end else if (wr) begin
            unique case (sel)
                REG_ACTIVE:     sh_active     <= data;
                REG_SYNC_START: sh_sync_start <= data;
                REG_SYNC_END:   sh_sync_end   <= data;
                REG_TOTAL:      sh_total      <= data;
            endcase
        end
    end

    // The copy samples the shadow before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_active     <= W'(DEF_ACTIVE);
            act_sync_start <= W'(DEF_SYNC_START);
            act_sync_end   <= W'(DEF_SYNC_END);
            act_total      <= W'(DEF_TOTAL);
        end else if (load) begin
            act_active     <= sh_active;
            act_sync_start <= sh_sync_start;
            act_sync_end   <= sh_sync_end;
            act_total      <= sh_total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
        end else if (advance) begin
            pos <= at_total ? '0 : pos + W'(1);
        end
    end

    assign at_total  = (pos == act_total);
    assign at_active = (pos == act_active);
    assign in_active = (pos < act_active);
    assign sync_on   = (pos >= act_sync_start) && (pos < act_sync_end);
    assign sync      = POL ? sync_on : ~sync_on;

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-programmable VGA timing generator with frame-atomic mode
// updates, line/frame strobes and a maskable three-source interrupt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int X_W              = 11,
    parameter int Y_W              = 10,
    parameter int FRAME_W          = 8,
    parameter bit HSYNC_POL        = 1'b0,
    parameter bit VSYNC_POL        = 1'b1,
    parameter int DEF_H_ACTIVE     = MODE_H_ACTIVE,
    parameter int DEF_H_SYNC_START = MODE_H_SYNC_START,
    parameter int DEF_H_SYNC_END   = MODE_H_SYNC_END,
    parameter int DEF_H_TOTAL      = MODE_H_TOTAL,
    parameter int DEF_V_ACTIVE     = MODE_V_ACTIVE,
    parameter int DEF_V_SYNC_START = MODE_V_SYNC_START,
    parameter int DEF_V_SYNC_END   = MODE_V_SYNC_END,
    parameter int DEF_V_TOTAL      = MODE_V_TOTAL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_addr,
    input  logic [X_W-1:0]     cfg_data,
    input  logic [2:0]         irq_enable,
    input  logic [2:0]         irq_clear,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic               cfg_pending,
    output logic [2:0]         irq_status,
    output logic               interrupt
);

    logic           h_wr, v_wr, line_wr;
    logic           h_total_hit, v_total_hit;
    logic           h_at_active, v_at_active;
    logic           h_in_active, v_in_active;
    logic           boundary, x_zero;
    logic [2:0]     irq_set;
    logic [Y_W-1:0] irq_line;
    axis_reg_e      reg_sel;

    assign reg_sel = axis_reg_e'(cfg_addr[1:0]);

    always_comb begin
        h_wr    = 1'b0;
        v_wr    = 1'b0;
        line_wr = 1'b0;
        if (cfg_wr) begin
            case (cfg_addr)
                ADDR_H_ACTIVE, ADDR_H_SYNC_START,
                ADDR_H_SYNC_END, ADDR_H_TOTAL:   h_wr = 1'b1;
                ADDR_V_ACTIVE, ADDR_V_SYNC_START,
                ADDR_V_SYNC_END, ADDR_V_TOTAL:   v_wr = 1'b1;
                ADDR_IRQ_LINE:                   line_wr = 1'b1;
                default: ;
            endcase
        end
    end

    vga_axis_counter #(
        .W              (X_W),
        .DEF_ACTIVE     (DEF_H_ACTIVE),
        .DEF_SYNC_START (DEF_H_SYNC_START),
        .DEF_SYNC_END   (DEF_H_SYNC_END),
        .DEF_TOTAL      (DEF_H_TOTAL),
        .POL            (HSYNC_POL)
    ) u_h (
        .clk       (clk),
        .rst       (rst),
        .advance   (1'b1),
        .load      (boundary),
        .wr        (h_wr),
        .sel       (reg_sel),
        .data      (cfg_data),
        .pos       (x),
        .at_total  (h_total_hit),
        .at_active (h_at_active),
        .in_active (h_in_active),
        .sync      (hsync)
    );

    vga_axis_counter #(
        .W              (Y_W),
        .DEF_ACTIVE     (DEF_V_ACTIVE),
        .DEF_SYNC_START (DEF_V_SYNC_START),
        .DEF_SYNC_END   (DEF_V_SYNC_END),
        .DEF_TOTAL      (DEF_V_TOTAL),
        .POL            (VSYNC_POL)
    ) u_v (
        .clk       (clk),
        .rst       (rst),
        .advance   (h_total_hit),
        .load      (boundary),
        .wr        (v_wr),
        .sel       (reg_sel),
        .data      (cfg_data[Y_W-1:0]),
        .pos       (y),
        .at_total  (v_total_hit),
        .at_active (v_at_active),
        .in_active (v_in_active),
        .sync      (vsync)
    );

    assign boundary = h_total_hit && v_total_hit;
    assign x_zero   = (x == '0);
    assign blank    = ~(h_in_active & v_in_active);

    always_comb begin
        irq_set             = '0;
        irq_set[IRQ_HBLANK] = h_at_active;
        irq_set[IRQ_VBLANK] = x_zero && v_at_active;
        irq_set[IRQ_LINE]   = x_zero && (y == irq_line);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            cfg_pending <= 1'b0;
            irq_line    <= '0;
            irq_status  <= '0;
            interrupt   <= 1'b0;
        end else begin
            line_start  <= x_zero;
            frame_start <= x_zero && (y == '0);
            if (boundary) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
            // A write on the boundary cycle misses this copy, so it stays pending.
            if (h_wr || v_wr) begin
                cfg_pending <= 1'b1;
            end else if (boundary) begin
                cfg_pending <= 1'b0;
            end
            if (line_wr) begin
                irq_line <= cfg_data[Y_W-1:0];
            end
            irq_status <= (irq_status & ~irq_clear) | irq_set;
            interrupt  <= |(irq_status & irq_enable);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shortened default frame
// (1328 x 16) so whole-frame behaviour fits in a short run.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [3:0]  cfg_addr;
    logic [10:0] cfg_data;
    logic [2:0]  irq_enable;
    logic [2:0]  irq_clear;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hsync, vsync, blank;
    logic        line_start, frame_start;
    logic [7:0]  frame_count;
    logic        cfg_pending;
    logic [2:0]  irq_status;
    logic        interrupt;

    int checks = 0;
    int errors = 0;
    int n = 0;

    localparam int N0 = 1328 * 16;
    localparam int M  = N0 + 128;
    localparam int N1 = M + 256;

    vga_timing_gen #(
        .DEF_V_ACTIVE     (12),
        .DEF_V_SYNC_START (13),
        .DEF_V_SYNC_END   (14),
        .DEF_V_TOTAL      (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .irq_enable  (irq_enable),
        .irq_clear   (irq_clear),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .cfg_pending (cfg_pending),
        .irq_status  (irq_status),
        .interrupt   (interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed %0h expected %0h",
                   tag, n, obs, exp);
        end
    endtask

    task automatic step_to(input int t);
        while (n < t) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [10:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        n++;
        cfg_wr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
    endtask

    initial begin
        cfg_wr     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        irq_enable = '0;
        irq_clear  = '0;
        do_reset();

        // Default line: sync, blank, strobes and hblank flag.
        for (int i = 0; i < 1328; i++) begin
            step_to(i);
            chk("x_scan", x, i);
            chk("hsync_scan", hsync, (i >= 1072 && i < 1176) ? 0 : 1);
            chk("blank_scan", blank, (i >= 1024) ? 1 : 0);
            if (i == 0) begin
                chk("rst_y", y, 0);
                chk("rst_vsync", vsync, 0);
                chk("rst_fc", frame_count, 0);
                chk("rst_pending", cfg_pending, 0);
                chk("rst_status", irq_status, 0);
                chk("rst_irq", interrupt, 0);
                chk("rst_ls", line_start, 0);
                chk("rst_fs", frame_start, 0);
            end
            if (i == 1) begin
                chk("ls_1", line_start, 1);
                chk("fs_1", frame_start, 1);
                chk("line_flag_y0", irq_status, 3'b100);
            end
            if (i == 2) chk("ls_2", line_start, 0);
            if (i == 1024) chk("hb_pre", irq_status, 3'b100);
            if (i == 1025) chk("hb_set", irq_status, 3'b101);
            if (i == 1026) chk("hb_masked", interrupt, 0);
        end
        step_to(1328);
        chk("wrap_x", x, 0);
        chk("wrap_y", y, 1);
        step_to(1329);
        chk("ls_line1", line_start, 1);
        chk("fs_line1", frame_start, 0);

        step_to(1400);
        irq_clear = 3'b111;
        step_to(1401);
        irq_clear = 3'b000;
        chk("clr_all", irq_status, 0);

        // Program the small mode; it must wait for the frame boundary.
        step_to(1410);
        wr(4'd0, 11'd8);
        wr(4'd1, 11'd10);
        wr(4'd2, 11'd12);
        wr(4'd3, 11'd15);
        wr(4'd4, 11'd4);
        wr(4'd5, 11'd5);
        wr(4'd6, 11'd6);
        wr(4'd7, 11'd7);
        chk("pend_set", cfg_pending, 1);
        step_to(1500);
        chk("old_mode_x", x, 172);
        chk("old_mode_y", y, 1);

        step_to(11 * 1328 + 5);
        chk("v11_blank", blank, 0);
        step_to(12 * 1328);
        chk("vb_pre", irq_status, 3'b001);
        step_to(12 * 1328 + 1);
        chk("vb_set", irq_status, 3'b011);
        step_to(12 * 1328 + 5);
        chk("v12_blank", blank, 1);
        chk("v12_vsync", vsync, 0);
        step_to(13 * 1328 + 5);
        chk("v13_y", y, 13);
        chk("v13_vsync", vsync, 1);
        step_to(14 * 1328 + 5);
        chk("v14_vsync", vsync, 0);
        step_to(N0 - 1);
        chk("bnd_x", x, 1327);
        chk("bnd_y", y, 15);
        chk("bnd_pend", cfg_pending, 1);
        chk("bnd_fc", frame_count, 0);
        step_to(N0);
        chk("new_x", x, 0);
        chk("new_y", y, 0);
        chk("new_pend", cfg_pending, 0);
        chk("new_fc", frame_count, 1);
        step_to(N0 + 1);
        chk("new_fs", frame_start, 1);

        // Small mode: 16 x 8.
        step_to(N0 + 7);
        chk("sm_x7", x, 7);
        chk("sm_blank7", blank, 0);
        step_to(N0 + 8);
        chk("sm_blank8", blank, 1);
        step_to(N0 + 9);
        chk("sm_hs9", hsync, 1);
        step_to(N0 + 10);
        chk("sm_hs10", hsync, 0);
        step_to(N0 + 11);
        chk("sm_hs11", hsync, 0);
        step_to(N0 + 12);
        chk("sm_hs12", hsync, 1);
        step_to(N0 + 15);
        chk("sm_x15", x, 15);
        step_to(N0 + 16);
        chk("sm_wrap_x", x, 0);
        chk("sm_wrap_y", y, 1);
        step_to(N0 + 67);
        chk("sm_y4", y, 4);
        chk("sm_y4_blank", blank, 1);
        chk("sm_y4_vs", vsync, 0);
        step_to(N0 + 80);
        chk("sm_y5_vs", vsync, 1);
        step_to(N0 + 96);
        chk("sm_y6_vs", vsync, 0);
        step_to(N0 + 127);
        chk("sm_end_x", x, 15);
        chk("sm_end_y", y, 7);
        chk("sm_end_fc", frame_count, 1);
        step_to(M);
        chk("sm_f2_x", x, 0);
        chk("sm_f2_y", y, 0);
        chk("sm_f2_fc", frame_count, 2);

        // Interrupts: only the line source enabled, irq_line = 3.
        step_to(M + 1);
        irq_clear = 3'b111;
        cfg_wr    = 1'b1;
        cfg_addr  = 4'd8;
        cfg_data  = 11'd3;
        step_to(M + 2);
        irq_clear  = 3'b000;
        cfg_wr     = 1'b0;
        irq_enable = 3'b100;
        step_to(M + 3);
        chk("irq_clr", irq_status, 0);
        chk("irq_clr_int", interrupt, 0);
        chk("irq_line_np", cfg_pending, 0);
        step_to(M + 9);
        chk("irq_hb", irq_status, 3'b001);
        step_to(M + 10);
        chk("irq_hb_mask", interrupt, 0);
        step_to(M + 48);
        chk("irq_l_pre", irq_status, 3'b001);
        step_to(M + 49);
        chk("irq_l_set", irq_status, 3'b101);
        chk("irq_l_lat1", interrupt, 0);
        step_to(M + 50);
        chk("irq_l_lat2", interrupt, 1);
        step_to(M + 65);
        chk("irq_vb", irq_status, 3'b111);
        step_to(M + 88);
        irq_clear = 3'b001;
        step_to(M + 89);
        chk("race_set_wins", irq_status, 3'b111);
        step_to(M + 90);
        irq_clear = 3'b000;
        chk("clear_alone", irq_status, 3'b110);
        step_to(M + 91);
        chk("irq_hold", interrupt, 1);
        step_to(M + 100);
        irq_clear = 3'b111;
        step_to(M + 101);
        irq_clear = 3'b000;
        chk("irq_clr2", irq_status, 0);
        step_to(M + 102);
        chk("irq_drop", interrupt, 0);

        // Write h_total on the boundary cycle itself.
        step_to(M + 127);
        chk("bw_x", x, 15);
        chk("bw_y", y, 7);
        wr(4'd3, 11'd19);
        chk("bw_pend", cfg_pending, 1);
        chk("bw_x0", x, 0);
        chk("bw_fc", frame_count, 3);
        step_to(M + 143);
        chk("bw_old_x15", x, 15);
        step_to(M + 144);
        chk("bw_old_wrap", x, 0);
        chk("bw_old_y1", y, 1);
        step_to(M + 255);
        chk("bw2_x", x, 15);
        chk("bw2_y", y, 7);
        chk("bw2_pend", cfg_pending, 1);
        step_to(N1);
        chk("bw_apply_x", x, 0);
        chk("bw_apply_y", y, 0);
        chk("bw_apply_pend", cfg_pending, 0);
        chk("bw_apply_fc", frame_count, 4);
        step_to(N1 + 10);
        chk("bw_hs10", hsync, 0);
        step_to(N1 + 16);
        chk("bw_x16", x, 16);
        step_to(N1 + 19);
        chk("bw_x19", x, 19);
        step_to(N1 + 20);
        chk("bw_wrap_x", x, 0);
        chk("bw_wrap_y", y, 1);

        // Mid-frame reset with a pending write.
        irq_enable = 3'b000;
        do_reset();
        step_to(600);
        wr(4'd3, 11'd15);
        chk("mr_pend", cfg_pending, 1);
        step_to(3 * 1328 + 500);
        chk("mr_x", x, 500);
        chk("mr_y", y, 3);
        chk("mr_status", irq_status, 3'b101);
        do_reset();
        chk("mr_rst_x", x, 0);
        chk("mr_rst_y", y, 0);
        chk("mr_rst_pend", cfg_pending, 0);
        chk("mr_rst_status", irq_status, 0);
        chk("mr_rst_fc", frame_count, 0);
        chk("mr_rst_hs", hsync, 1);
        chk("mr_rst_blank", blank, 0);
        step_to(16);
        chk("mr_def_x16", x, 16);
        step_to(1024);
        chk("mr_def_blank", blank, 1);
        step_to(1328);
        chk("mr_def_wrap_x", x, 0);
        chk("mr_def_wrap_y", y, 1);
        chk("mr_def_pend", cfg_pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
